// File: rtl/router_input_port.sv
// Router input port: flit FIFO feeding an IDLE/REQ/XFER request FSM toward the arbiter.
// Ports: clk, rst_n (async low); link_valid/link_data/link_tail/link_ready upstream;
//        port_req/port_block to arbiter; out_valid/out_data/out_tail to crossbar; fwd_count stats.
// Latency: a pushed flit raises port_req one cycle later. Backpressure: link_ready drops when full,
//          port_block stalls the head with no change to state, pointers or head.
// Optional macro ROUTER_INPUT_PORT_STATS_EN adds a saturating forwarded-packet counter.
module router_input_port #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              link_valid,
  input  logic [DATA_W-1:0] link_data,
  input  logic              link_tail,
  output logic              link_ready,
  output logic              port_req,
  input  logic              port_block,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_tail,
  output logic [15:0]       fwd_count
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic [DATA_W:0] head;
  state_t          state;
  state_t          state_next;

  // Full is judged on current occupancy only, so a same-cycle pop never frees a slot.
  assign link_ready = (count != CW'(DEPTH));
  assign push       = link_valid && link_ready;
  assign out_valid  = port_req && !port_block;
  assign pop        = out_valid;

  assign head     = mem[rd_ptr];
  assign out_data = head[DATA_W-1:0];
  assign out_tail = head[DATA_W];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {link_tail, link_data};
    end
  end

  // DEPTH is a power of two, so the natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Kept apart from next-state logic: port_req feeds pop, which feeds count_next.
  always_comb begin
    port_req = 1'b0;
    case (state)
      REQ:     port_req = 1'b1;
      XFER:    port_req = (count != '0);  // empty mid-packet -> bubble, stay locked
      default: port_req = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (count_next != '0) state_next = REQ;
      end
      REQ: begin
        if (pop) begin
          if (!out_tail)               state_next = XFER;
          else if (count_next != '0)   state_next = REQ;
          else                         state_next = IDLE;
        end
      end
      XFER: begin
        if (pop && out_tail) begin
          state_next = (count_next != '0) ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ROUTER_INPUT_PORT_STATS_EN
  logic [15:0] fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q <= '0;
    end else if (pop && out_tail && (fwd_cnt_q != 16'hFFFF)) begin
      fwd_cnt_q <= fwd_cnt_q + 16'd1;
    end
  end

  assign fwd_count = fwd_cnt_q;
`else
  assign fwd_count = '0;
`endif

endmodule

// File: tb/tb_router_input_port.sv
module tb_router_input_port;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          link_valid;
  logic [DW-1:0] link_data;
  logic          link_tail;
  logic          link_ready;
  logic          port_req;
  logic          port_block;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_tail;
  logic [15:0]   fwd_count;

  router_input_port #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .link_valid (link_valid),
    .link_data  (link_data),
    .link_tail  (link_tail),
    .link_ready (link_ready),
    .port_req   (port_req),
    .port_block (port_block),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_tail   (out_tail),
    .fwd_count  (fwd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference: a queue of {tail,data} flits and a packet counter.
  // A port with buffered flits always requests; a free slot always means ready.
  logic [DW:0] mq[$];
  int unsigned mcnt = 0;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          t;
    logic          b;
    logic          e_rdy;
    logic          e_req;
    logic          e_ov;
    logic [DW-1:0] e_dat;
    logic          e_tail;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic logic [15:0] exp_fwd();
`ifdef ROUTER_INPUT_PORT_STATS_EN
    return (mcnt > 16'hFFFF) ? 16'hFFFF : mcnt[15:0];
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_check(input string tag);
    logic e_rdy, e_req, e_ov;
    e_rdy = (mq.size() != DEPTH);
    e_req = (mq.size() != 0);
    e_ov  = e_req && !port_block;
    check({tag, "/link_ready"}, link_ready, e_rdy);
    check({tag, "/port_req"},   port_req,   e_req);
    check({tag, "/out_valid"},  out_valid,  e_ov);
    if (e_ov) begin
      check({tag, "/out_data"}, out_data, mq[0][DW-1:0]);
      check({tag, "/out_tail"}, out_tail, mq[0][DW]);
    end
    check({tag, "/fwd_count"}, fwd_count, exp_fwd());
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic t, input logic b);
    logic do_pop, do_push;
    logic [DW:0] h;
    do_pop  = (mq.size() != 0) && !b;
    do_push = v && (mq.size() != DEPTH);
    if (do_pop) begin
      h = mq.pop_front();
      if (h[DW]) mcnt++;
    end
    if (do_push) mq.push_back({t, d});
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cyc(input string tag, input logic v, input logic [DW-1:0] d,
                     input logic t, input logic b);
    link_valid = v;
    link_data  = d;
    link_tail  = t;
    port_block = b;
    @(negedge clk);
    model_check(tag);
    @(posedge clk);
    model_step(v, d, t, b);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {v, d, t, b, exp ready, exp req, exp out_valid, exp data, exp tail}
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0};
    tbl[13] = '{1'b1, 8'h14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h14, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    rst_n      = 1'b0;
    link_valid = 1'b0;
    link_data  = '0;
    link_tail  = 1'b0;
    port_block = 1'b0;
    #1;
    check("reset/link_ready", link_ready, 1'b1);
    check("reset/port_req",   port_req,   1'b0);
    check("reset/out_valid",  out_valid,  1'b0);
    check("reset/fwd_count",  fwd_count,  16'h0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-flit packet, fill-to-full with blocked arbiter, drain, bubble, tail.
    for (int i = 0; i < 16; i++) begin
      link_valid = tbl[i].v;
      link_data  = tbl[i].d;
      link_tail  = tbl[i].t;
      port_block = tbl[i].b;
      @(negedge clk);
      check($sformatf("vec%0d/link_ready", i), link_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d/port_req", i),   port_req,   tbl[i].e_req);
      check($sformatf("vec%0d/out_valid", i),  out_valid,  tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        check($sformatf("vec%0d/out_data", i), out_data, tbl[i].e_dat);
        check($sformatf("vec%0d/out_tail", i), out_tail, tbl[i].e_tail);
      end
      model_check($sformatf("vec%0d", i));
      @(posedge clk);
      model_step(tbl[i].v, tbl[i].d, tbl[i].t, tbl[i].b);
      #1;
    end

    // 3-flit packet held by port_block for three cycles after port_req rises.
    cyc("blk3", 1'b1, 8'h31, 1'b0, 1'b1);
    cyc("blk3", 1'b1, 8'h32, 1'b0, 1'b1);
    cyc("blk3", 1'b1, 8'h33, 1'b1, 1'b1);
    cyc("blk3", 1'b0, 8'h00, 1'b0, 1'b1);
    cyc("blk3", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("blk3", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("blk3", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("blk3", 1'b0, 8'h00, 1'b0, 1'b0);

    // Starvation: tail arrives four cycles after the body.
    cyc("starve", 1'b1, 8'h41, 1'b0, 1'b0);
    cyc("starve", 1'b1, 8'h42, 1'b0, 1'b0);
    cyc("starve", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("starve", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("starve", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("starve", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("starve", 1'b1, 8'h43, 1'b1, 1'b0);
    cyc("starve", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("starve", 1'b0, 8'h00, 1'b0, 1'b0);

    // Mid-packet asynchronous reset with three flits buffered.
    cyc("arst", 1'b1, 8'h51, 1'b0, 1'b1);
    cyc("arst", 1'b1, 8'h52, 1'b0, 1'b0);
    cyc("arst", 1'b1, 8'h53, 1'b0, 1'b1);
    cyc("arst", 1'b1, 8'h54, 1'b0, 1'b1);
    check("arst/pre_port_req", port_req, 1'b1);
    link_valid = 1'b0;
    port_block = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst/port_req",   port_req,   1'b0);
    check("arst/link_ready", link_ready, 1'b1);
    check("arst/out_valid",  out_valid,  1'b0);
    check("arst/fwd_count",  fwd_count,  16'h0);
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("arst_post", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("arst_post", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("arst_post", 1'b1, 8'h61, 1'b1, 1'b0);
    cyc("arst_post", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("arst_post", 1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic: balanced phase, then a congested phase that keeps the buffer full.
    for (int i = 0; i < 3000; i++) begin
      cyc("rnd", ($urandom_range(0, 99) < 70), DW'($urandom), ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 30));
    end
    for (int i = 0; i < 1500; i++) begin
      cyc("rnd_full", ($urandom_range(0, 99) < 90), DW'($urandom), ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 99) < 80));
    end
    for (int i = 0; i < 12; i++) begin
      cyc("drain", 1'b0, 8'h00, 1'b0, 1'b0);
    end

`ifdef ROUTER_INPUT_PORT_STATS_EN
    // Back-to-back single-flit packets until the counter must have saturated.
    link_valid = 1'b1;
    link_data  = 8'h77;
    link_tail  = 1'b1;
    port_block = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      model_step(1'b1, 8'h77, 1'b1, 1'b0);
    end
    #1;
    link_valid = 1'b0;
    check("sat/fwd_count", fwd_count, 16'hFFFF);
    cyc("sat", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("sat", 1'b0, 8'h00, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/router_input_port.md
ROUTER_INPUT_PORT -- requirements
Module: router_input_port

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, flit payload width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, flit buffer entries; DEPTH SHALL be a power of two, at least 2.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port link_valid  input  1  upstream link offers a flit this cycle.
REQ-006 Port link_data  input  DATA_W  upstream flit payload.
REQ-007 Port link_tail  input  1  offered flit is the last flit of its packet.
REQ-008 Port link_ready  output  1  buffer accepts a flit this cycle.
REQ-009 Port port_req  output  1  request to the arbiter's per-port input (port1/port2/port3).
REQ-010 Port port_block  input  1  block from the arbiter for this port.
REQ-011 Port out_valid  output  1  flit forwarded to the crossbar mux this cycle.
REQ-012 Port out_data  output  DATA_W  forwarded flit payload.
REQ-013 Port out_tail  output  1  forwarded flit is a tail.
REQ-014 Port fwd_count  output  16  forwarded-packet counter (see Configuration).

Function
REQ-015 Push SHALL occur when link_valid && link_ready; link_ready SHALL equal (occupancy != DEPTH).
REQ-016 A full buffer SHALL NOT accept a push even if a pop occurs the same cycle.
REQ-017 Pop SHALL occur when out_valid; out_valid SHALL equal port_req && !port_block, combinational.
REQ-018 out_data/out_tail SHALL be the buffer head entry (combinational); values while out_valid=0 are don't-care.
REQ-019 Simultaneous push and pop on a non-full, non-empty buffer SHALL leave occupancy unchanged; write/read pointers SHALL wrap modulo DEPTH.
REQ-020 A pushed flit SHALL be visible at the head no earlier than the following cycle (one-cycle minimum latency link to port_req).
REQ-021 FSM states: IDLE, REQ, XFER.
REQ-022 IDLE: port_req=0; SHALL go to REQ when occupancy becomes non-zero.
REQ-023 REQ: port_req=1; on pop of non-tail head SHALL go to XFER; on pop of tail head SHALL go to REQ if buffer still non-empty after the pop, else IDLE; without pop SHALL stay.
REQ-024 XFER (packet locked): port_req SHALL be 1 only while buffer non-empty; empty buffer mid-packet SHALL hold XFER with port_req=0 (bubble).
REQ-025 XFER: on pop of tail SHALL go to REQ if buffer non-empty after pop, else IDLE.
REQ-026 port_block asserted in any state SHALL stall without changing state, pointers or head.
REQ-027 Single-flit packets (tail on head) SHALL transition REQ->REQ/IDLE directly, never entering XFER.

Reset
REQ-028 rst_n=0 SHALL immediately clear pointers and occupancy, force IDLE, and drive port_req=0, out_valid=0, link_ready=1 and fwd_count=0, regardless of clock.
REQ-029 Reset mid-packet SHALL discard all buffered flits; first flit after reset release SHALL be treated as a head.

Configuration
REQ-030 With macro ROUTER_INPUT_PORT_STATS_EN defined, fwd_count SHALL increment by 1 on each popped tail flit and saturate at 16'hFFFF.
REQ-031 Without ROUTER_INPUT_PORT_STATS_EN, fwd_count SHALL be constant 0 and no counter register SHALL exist; all other behaviour identical.

Verification
REQ-032 Single-flit packet: push data 8'hA5 tail=1, port_block=0 -> port_req=1 next cycle, out_valid=1 out_data=8'hA5 out_tail=1, then IDLE; fwd_count=1 with macro.
REQ-033 Fill: DEPTH=4, 5 consecutive link_valid with port_block=1 -> link_ready=0 after 4 pushes, 5th flit held upstream, no out_valid.
REQ-034 3-flit packet with port_block=1 for 3 cycles after port_req rises -> no pop during block, then flits 1,2,3 forwarded on consecutive cycles, state XFER between head and tail.
REQ-035 Mid-packet starvation: head+body forwarded, tail arrives 4 cycles later -> port_req=0 during gap, state XFER held, tail forwarded one cycle after arrival (port_block=0).
REQ-036 Async reset: assert rst_n=0 between clock edges with 3 flits buffered -> port_req=0, link_ready=1 immediately; no forwarded flit after release.
REQ-037 Saturation (macro defined): force 65537 tail pops -> fwd_count=16'hFFFF.
